rs232in: RTL
============

Name: rs232in

Overview:
- Asynchronous serial receiver, 8N1, LSB first: the receive-side counterpart of the SoC's serial transmitter.
- Sits between the board's RX pin and the SoC peripheral bus.
- Oversamples the line with the system clock, recovers one byte per frame and holds it in a one-entry holding register until the CPU reads it.
- Reports framing errors and overruns.

Parameters:
- bps, 57_600, line bit rate.
- frequency, 25_000_000, clock frequency in Hz.
- period, (frequency + bps/2) / bps, clocks per bit (434 at defaults); overridable for simulation.
- CNT_W, 13, bit-timer width; 2^CNT_W must exceed period.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  1  asynchronous RX line, idle high.
- received_data  output  8  last good byte; valid while data_ready=1.
- data_ready  output  1  holding register full.
- re  input  1  read strobe; one-cycle pulse consumes the held byte.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky; a byte was lost because the holding register was full.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Synchronizer
  - Two-flop synchronizer on serial_in, both flops reset to 1.
  - All logic uses the synchronized value rx; rx lags the pin by 2 cycles.
- Reset values
  - received_data=0, data_ready=0, framing_error=0, overrun=0, busy=0.
  - FSM=IDLE, bit timer=0, bit count=0.
  - Reset mid-frame aborts the frame; nothing is delivered.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE
  - rx=0 (falling edge) -> START; timer loads period/2 - 1 (integer division).
- Timer
  - The timer counts down one per clock; "expire" means the timer is 0 in that cycle.
  - Every reload after START uses period - 1, so samples land mid-bit.
- START expire
  - rx=1 -> IDLE (glitch/false start, no flags).
  - rx=0 -> DATA; bit count=0; timer reload.
- DATA expire
  - Shift rx into the MSB of the shift register (LSB-first reassembly).
  - After the 8th sample -> STOP; timer reload.
- STOP expire
  - rx=1 -> IDLE, byte delivered.
  - rx=0 -> framing_error pulses 1 cycle; byte discarded; -> BREAK.
- BREAK: wait for rx=1 -> IDLE. This keeps a held-low line (break) from producing phantom frames.
- Returning to IDLE at stop-bit mid gives a half-bit of resync margin, so back-to-back frames are tolerated.
- Delivery
  - Occurs in the cycle after the stop-bit sample.
  - received_data <= byte; data_ready <= 1.
  - If data_ready was already 1 and no re in the delivery cycle, set overrun. The new byte still overwrites the old one (newest wins).
- re handling
  - re with data_ready=1 and no simultaneous delivery: data_ready <= 0 and overrun <= 0.
  - re in the same cycle as delivery: new byte loaded, data_ready stays 1, overrun cleared, overrun not set.
  - re with data_ready=0: no effect.
- busy = (state != IDLE).
- Arithmetic
  - Timer is CNT_W bits unsigned, reload only, no wrap.
  - Bit count is 3 bits plus terminal detect.
- Total latency: falling start edge on pin to data_ready = 2 + period/2 + 9*period + 1 clocks.

Optional Feature:
RS232IN_MAJORITY_EN:
- Defined
  - Each sample point, including start-confirm and stop, takes a 2-of-3 majority of rx at timer values 1, 0 and the cycle after 0.
  - The decision is made one cycle after expire, so every state transition and delivery is one clock later.
  - Requires period >= 4.
- Undefined: single sample at expire, as above.

Test Plan:
- Sim with frequency=1_000_000, bps=100_000 (period=10). Send 0x55 at bit-exact timing -> data_ready=1 with received_data=0x55 exactly 2+5+90+1=98 clocks after the start edge; overrun=0, framing_error=0.
- Send 0xA3 then 0x0F back-to-back, re pulsed after each delivery -> reads 0xA3 then 0x0F; data_ready drops the cycle after each re.
- Send 0x11 then 0x22 with no re -> data_ready=1, received_data=0x22, overrun=1. A later re clears both.
- Frame with stop bit 0 (data 0x7E), line held low 30 clocks -> framing_error pulses once, data_ready stays 0, busy=1 until rx returns high. Next frame 0x3C is received correctly.
- 3-clock low glitch on idle line -> returns to IDLE, no flags, data_ready=0.
- Assert reset during bit 4 of 0xFF -> all outputs 0 next cycle. The remaining bits produce no delivery; the next clean frame 0x81 is received.

Source files
------------

// File: rtl/rs232in.sv
// rs232in: 8N1 asynchronous serial receiver, LSB first.
// The line is oversampled with the system clock and each bit is sampled near its middle.
// Each good byte goes into a one-entry holding register, which the CPU empties with re.
// Framing errors are reported as a one-cycle pulse. Overrun is sticky.
// Optional build macro RS232IN_MAJORITY_EN: each sample point takes a 2-of-3 majority
// around the bit middle, and every decision lands one clock later.
module rs232in #(
    parameter int bps       = 57_600,
    parameter int frequency = 25_000_000,
    parameter int period    = (frequency + bps / 2) / bps,
    parameter int CNT_W     = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] received_data,
    output logic       data_ready,
    input  logic       re,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(period / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(period - 1);
    localparam logic [CNT_W-1:0] T_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] T_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             sync1_r;
    logic             rx_r;
    state_t           state_r,   state_s;
    logic [CNT_W-1:0] timer_r,   timer_s;
    logic [2:0]       count_r,   count_s;
    logic [7:0]       shift_r,   shift_s;
    logic             deliver_r, deliver_s;
    logic             ferr_s;
    logic             timing_s;
    logic             sample_event_s;
    logic             sample_bit_s;

    // Two-flop synchronizer on the raw RX pin. It idles high so that reset sees no start edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b1;
            rx_r    <= 1'b1;
        end else begin
            sync1_r <= serial_in;
            rx_r    <= sync1_r;
        end
    end

    assign timing_s = (state_r == START) || (state_r == DATA) || (state_r == STOP);

`ifdef RS232IN_MAJORITY_EN
    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        maj3 = (a & b) | (a & c) | (b & c);
    endfunction

    logic samp_t1_r;
    logic samp_t0_r;
    logic decide_r;

    // Capture rx at timer values 1 and 0. Raise the decision flag in the cycle after expiry.
    always_ff @(posedge clock) begin
        if (reset) begin
            samp_t1_r <= 1'b1;
            samp_t0_r <= 1'b1;
            decide_r  <= 1'b0;
        end else begin
            samp_t1_r <= (timer_r == T_ONE)  ? rx_r : samp_t1_r;
            samp_t0_r <= (timer_r == T_ZERO) ? rx_r : samp_t0_r;
            decide_r  <= timing_s && (timer_r == T_ZERO);
        end
    end

    assign sample_event_s = decide_r;
    assign sample_bit_s   = maj3(samp_t1_r, samp_t0_r, rx_r);
`else
    assign sample_event_s = timing_s && (timer_r == T_ZERO);
    assign sample_bit_s   = rx_r;
`endif

    // Next-state logic. The timer reloads on expiry in every timed state, so samples stay mid-bit.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        count_s   = count_r;
        shift_s   = shift_r;
        deliver_s = 1'b0;
        ferr_s    = 1'b0;

        if (timing_s) begin
            if (timer_r == T_ZERO) begin
                timer_s = FULL_LOAD;
            end else begin
                timer_s = timer_r - T_ONE;
            end
        end else begin
            timer_s = T_ZERO;
        end

        case (state_r)
            IDLE: begin
                if (!rx_r) begin
                    state_s = START;
                    timer_s = HALF_LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (sample_event_s) begin
                    if (sample_bit_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DATA;
                        count_s = 3'd0;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (sample_event_s) begin
                    shift_s = {sample_bit_s, shift_r[7:1]};
                    if (count_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        count_s = count_r + 3'd1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (sample_event_s) begin
                    if (sample_bit_s) begin
                        state_s   = IDLE;
                        deliver_s = 1'b1;
                    end else begin
                        state_s = BREAK;
                        ferr_s  = 1'b1;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            BREAK: begin
                if (rx_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = BREAK;
                end
            end
            default: begin
                state_s = IDLE;
                timer_s = T_ZERO;
                count_s = 3'd0;
            end
        endcase
    end

    // Receiver state registers, plus the registered busy and framing-error outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            timer_r       <= T_ZERO;
            count_r       <= 3'd0;
            shift_r       <= 8'h00;
            deliver_r     <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_r       <= state_s;
            timer_r       <= timer_s;
            count_r       <= count_s;
            shift_r       <= shift_s;
            deliver_r     <= deliver_s;
            framing_error <= ferr_s;
            busy          <= (state_s != IDLE);
        end
    end

    // Holding register. It is loaded one cycle after a good stop bit and emptied by re.
    // The newest byte always wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            received_data <= 8'h00;
            data_ready    <= 1'b0;
            overrun       <= 1'b0;
        end else if (deliver_r) begin
            received_data <= shift_r;
            data_ready    <= 1'b1;
            if (re) begin
                overrun <= 1'b0;
            end else if (data_ready) begin
                overrun <= 1'b1;
            end else begin
                overrun <= overrun;
            end
        end else if (re && data_ready) begin
            data_ready <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data_ready <= data_ready;
            overrun    <= overrun;
        end
    end

endmodule
